// File: rtl/nvram_backup_engine_if.sv
// Host load/save streams and nibble-array bus of the NVRAM backup engine.
// master: engine side; slave: host + array side.
interface nvram_backup_engine_if #(
    parameter int AW = 8,
    parameter int DW = 4
);
    logic          ld_req;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          sv_valid;
    logic [AW-1:0] sv_addr;
    logic [DW-1:0] sv_data;
    logic          sv_ready;
    logic [AW-1:0] nv_a;
    logic [DW-1:0] nv_i;
    logic [DW-1:0] nv_o;
    logic          nv_ce_n;
    logic          nv_rw_n;

    modport master (
        input  ld_req, ld_valid, ld_data, sv_ready, nv_o,
        output ld_ready, sv_valid, sv_addr, sv_data,
        output nv_a, nv_i, nv_ce_n, nv_rw_n
    );

    modport slave (
        output ld_req, ld_valid, ld_data, sv_ready, nv_o,
        input  ld_ready, sv_valid, sv_addr, sv_data,
        input  nv_a, nv_i, nv_ce_n, nv_rw_n
    );
endinterface

// File: rtl/nvram_backup_engine.sv
// Save/restore sequencer in front of the nibble NVRAM array.
// Ports: clk, reset_n, cpu_* bus, busy, ld_err, bus (load/save/array).
module nvram_backup_engine #(
    parameter int AW           = 8,
    parameter int DW           = 4,
    parameter int LOAD_TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_i,
    output logic [DW-1:0] cpu_o,
    input  logic          cpu_ce_n,
    input  logic          cpu_rw_n,
    input  logic          cpu_store,
    output logic          cpu_wr_drop,
    output logic          busy,
    output logic          ld_err,
    nvram_backup_engine_if.master bus
);
    localparam int TW = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LD_WAIT, LD_SETUP, LD_WRITE, SV_READ, SV_OUT
    } state_t;

    state_t        state, state_nx;
    logic [AW-1:0] count, count_nx;
    logic [AW-1:0] a_q, a_nx;
    logic [DW-1:0] d_q, d_nx;
    logic [AW-1:0] sv_addr_q, sv_addr_nx;
    logic [DW-1:0] sv_data_q, sv_data_nx;
    logic          sv_valid_q, sv_valid_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          ld_err_q, ld_err_nx;
    logic          busy_q;
    logic          store_q, store_pend, start_sv;
    logic          wr_q, wr_drop_q;
    logic          wr_act;

    assign wr_act      = ~cpu_ce_n & ~cpu_rw_n;
    assign busy        = busy_q;
    assign ld_err      = ld_err_q;
    assign cpu_wr_drop = wr_drop_q;
    assign bus.sv_addr  = sv_addr_q;
    assign bus.sv_data  = sv_data_q;
    assign bus.sv_valid = sv_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            a_q        <= '0;
            d_q        <= '0;
            sv_addr_q  <= '0;
            sv_data_q  <= '0;
            sv_valid_q <= 1'b0;
            timer      <= '0;
            ld_err_q   <= 1'b0;
            busy_q     <= 1'b0;
            store_q    <= 1'b0;
            store_pend <= 1'b0;
            wr_q       <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            count      <= count_nx;
            a_q        <= a_nx;
            d_q        <= d_nx;
            sv_addr_q  <= sv_addr_nx;
            sv_data_q  <= sv_data_nx;
            sv_valid_q <= sv_valid_nx;
            timer      <= timer_nx;
            ld_err_q   <= ld_err_nx;
            busy_q     <= (state_nx != IDLE);
            store_q    <= cpu_store;
            // A store edge seen while busy waits here until IDLE.
            store_pend <= (cpu_store & ~store_q) | (store_pend & ~start_sv);
            wr_q       <= wr_act;
            wr_drop_q  <= (state != IDLE) & wr_act & ~wr_q;
        end
    end

    always_comb begin
        state_nx    = state;
        count_nx    = count;
        a_nx        = a_q;
        d_nx        = d_q;
        sv_addr_nx  = sv_addr_q;
        sv_data_nx  = sv_data_q;
        sv_valid_nx = sv_valid_q;
        timer_nx    = timer;
        ld_err_nx   = ld_err_q;
        start_sv    = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.ld_req) begin
                    state_nx  = LD_WAIT;
                    count_nx  = '0;
                    ld_err_nx = 1'b0;
                    timer_nx  = '0;
                end else if (store_pend) begin
                    state_nx = SV_READ;
                    count_nx = '0;
                    start_sv = 1'b1;
                end
            end
            LD_WAIT: begin
                if (bus.ld_valid) begin
                    state_nx = LD_SETUP;
                    a_nx     = count;
                    d_nx     = bus.ld_data;
                    timer_nx = '0;
                end else if (timer == TW'(LOAD_TIMEOUT - 1)) begin
                    state_nx  = IDLE;
                    ld_err_nx = 1'b1;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            LD_SETUP: state_nx = LD_WRITE;
            LD_WRITE: begin
                if (count == '1) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = LD_WAIT;
                    count_nx = count + 1'b1;
                end
            end
            SV_READ: begin
                state_nx    = SV_OUT;
                sv_data_nx  = bus.nv_o;
                sv_addr_nx  = count;
                sv_valid_nx = 1'b1;
            end
            SV_OUT: begin
                if (bus.sv_ready) begin
                    sv_valid_nx = 1'b0;
                    if (count == '1) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = SV_READ;
                        count_nx = count + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Array pins: CPU pass-through in IDLE, engine-driven otherwise.
    // a_q/d_q stay put after the write strobe so nothing moves
    // on the edge where nv_rw_n returns high.
    always_comb begin
        bus.nv_a     = a_q;
        bus.nv_i     = d_q;
        bus.nv_ce_n  = 1'b1;
        bus.nv_rw_n  = 1'b1;
        bus.ld_ready = 1'b0;
        cpu_o        = {DW{1'b1}};
        if (!reset_n) begin
            bus.nv_a = '0;
            bus.nv_i = '0;
            cpu_o    = bus.nv_o;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.nv_a    = cpu_a;
                    bus.nv_i    = cpu_i;
                    bus.nv_ce_n = cpu_ce_n;
                    bus.nv_rw_n = cpu_rw_n;
                    cpu_o       = bus.nv_o;
                end
                LD_WAIT:  bus.ld_ready = 1'b1;
                LD_SETUP: bus.nv_ce_n  = 1'b0;
                LD_WRITE: begin
                    bus.nv_ce_n = 1'b0;
                    bus.nv_rw_n = 1'b0;
                end
                SV_READ: begin
                    bus.nv_a    = count;
                    bus.nv_ce_n = 1'b0;
                end
                SV_OUT:  bus.nv_a = count;
                default: bus.nv_a = a_q;
            endcase
        end
    end
endmodule

// File: tb/tb_nvram_backup_engine.sv
// Directed bench for nvram_backup_engine with a behavioural array.
// Tests: reset, cpu access, load, save, timeout, write drop, reset abort.
module tb_nvram_backup_engine;
    localparam int AW = 8;
    localparam int DW = 4;
    localparam int TO = 4096;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] cpu_a;
    logic [DW-1:0] cpu_i;
    logic [DW-1:0] cpu_o;
    logic          cpu_ce_n;
    logic          cpu_rw_n;
    logic          cpu_store;
    logic          cpu_wr_drop;
    logic          busy;
    logic          ld_err;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [256];

    nvram_backup_engine_if #(.AW(AW), .DW(DW)) bus ();

    nvram_backup_engine #(.AW(AW), .DW(DW), .LOAD_TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_a       (cpu_a),
        .cpu_i       (cpu_i),
        .cpu_o       (cpu_o),
        .cpu_ce_n    (cpu_ce_n),
        .cpu_rw_n    (cpu_rw_n),
        .cpu_store   (cpu_store),
        .cpu_wr_drop (cpu_wr_drop),
        .busy        (busy),
        .ld_err      (ld_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    assign bus.nv_o = mem[bus.nv_a];
    always @(posedge clk)
        if (!bus.nv_ce_n && !bus.nv_rw_n) mem[bus.nv_a] <= bus.nv_i;

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        cpu_a = 8'h33; cpu_i = 4'h9;
        cpu_ce_n = 1'b0; cpu_rw_n = 1'b0;
        cpu_store = 1'b0;
        bus.ld_req = 1'b0; bus.ld_valid = 1'b0;
        bus.ld_data = '0; bus.sv_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] <= '0;
        #3;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst_busy got=%0h exp=0", busy);
        end
        total++;
        if (bus.ld_ready !== 1'b0 || bus.sv_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_hs got=%0b%0b exp=00",
                     bus.ld_ready, bus.sv_valid);
        end
        total++;
        if (bus.sv_addr !== 8'h00 || bus.sv_data !== 4'h0) begin
            bad++;
            $display("FAIL rst_sv got=%0h/%0h exp=0/0",
                     bus.sv_addr, bus.sv_data);
        end
        total++;
        if (ld_err !== 1'b0 || cpu_wr_drop !== 1'b0) begin
            bad++;
            $display("FAIL rst_flags got=%0b%0b exp=00", ld_err, cpu_wr_drop);
        end
        total++;
        if (bus.nv_ce_n !== 1'b1 || bus.nv_rw_n !== 1'b1 ||
            bus.nv_a !== 8'h00 || bus.nv_i !== 4'h0) begin
            bad++;
            $display("FAIL rst_nv got=%0b%0b %0h %0h exp=11 0 0",
                     bus.nv_ce_n, bus.nv_rw_n, bus.nv_a, bus.nv_i);
        end
        cpu_ce_n = 1'b1; cpu_rw_n = 1'b1;
        tick; tick;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_cpu_access;
        cpu_a = 8'h10; cpu_i = 4'h5;
        cpu_ce_n = 1'b0; cpu_rw_n = 1'b0;
        tick;
        cpu_rw_n = 1'b1;
        #1;
        total++;
        if (cpu_o !== 4'h5) begin
            bad++; $display("FAIL cpu_rd got=%0h exp=5", cpu_o);
        end
        total++;
        if (busy !== 1'b0 || cpu_wr_drop !== 1'b0) begin
            bad++;
            $display("FAIL cpu_idle got=%0b%0b exp=00", busy, cpu_wr_drop);
        end
        cpu_ce_n = 1'b1;
        tick;
    endtask

    task automatic test_load;
        int sent, pulses, viol, cyc, merr;
        logic acc, prev_rw;
        logic [AW-1:0] prev_a, ea;
        logic [DW-1:0] prev_i, v;
        bus.ld_req = 1'b1;
        tick;
        bus.ld_req = 1'b0;
        total++;
        if (busy !== 1'b1 || bus.ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL ld_start got=%0b%0b exp=11", busy, bus.ld_ready);
        end
        sent = 0; pulses = 0; viol = 0; cyc = 0;
        prev_rw = 1'b1; prev_a = '0; prev_i = '0;
        bus.ld_valid = 1'b1;
        while (busy && cyc < 2000) begin
            v = sent[3:0];
            bus.ld_data = v;
            acc = bus.ld_ready;
            if (bus.nv_rw_n == 1'b0) begin
                ea = pulses[7:0];
                v = pulses[3:0];
                pulses++;
                if (prev_rw == 1'b0) viol++;
                if (bus.nv_a !== prev_a || bus.nv_i !== prev_i) viol++;
                if (bus.nv_a !== ea || bus.nv_i !== v) viol++;
            end
            prev_rw = bus.nv_rw_n;
            prev_a = bus.nv_a;
            prev_i = bus.nv_i;
            tick;
            if (acc) sent++;
            cyc++;
        end
        bus.ld_valid = 1'b0;
        total++;
        if (sent != 256 || pulses != 256) begin
            bad++;
            $display("FAIL ld_count got=%0d/%0d exp=256/256", sent, pulses);
        end
        total++;
        if (viol != 0) begin
            bad++; $display("FAIL ld_strobe got=%0d exp=0 violations", viol);
        end
        total++;
        if (busy !== 1'b0 || ld_err !== 1'b0) begin
            bad++; $display("FAIL ld_end got=%0b%0b exp=00", busy, ld_err);
        end
        merr = 0;
        for (int k = 0; k < 256; k++) begin
            v = k[3:0];
            if (mem[k] !== v) merr++;
        end
        total++;
        if (merr != 0) begin
            bad++; $display("FAIL ld_array got=%0d exp=0 bad cells", merr);
        end
    endtask

    task automatic test_save;
        int got, err, cyc;
        logic stall;
        logic [AW-1:0] ha, ea;
        logic [DW-1:0] hd, ed;
        cpu_store = 1'b1;
        tick; tick;
        total++;
        if (busy !== 1'b1 || cpu_o !== 4'hF) begin
            bad++;
            $display("FAIL sv_start got=%0b %0h exp=1 f", busy, cpu_o);
        end
        got = 0; err = 0; cyc = 0; stall = 1'b0;
        ha = '0; hd = '0;
        while (busy && cyc < 3000) begin
            bus.sv_ready = cyc[0];
            #1;
            if (cpu_o !== 4'hF) err++;
            if (stall && (bus.sv_valid !== 1'b1 ||
                          bus.sv_addr !== ha || bus.sv_data !== hd)) err++;
            stall = 1'b0;
            if (bus.sv_valid) begin
                if (bus.sv_ready) begin
                    ea = got[7:0];
                    ed = got[3:0];
                    if (bus.sv_addr !== ea || bus.sv_data !== ed) err++;
                    got++;
                end else begin
                    stall = 1'b1;
                    ha = bus.sv_addr;
                    hd = bus.sv_data;
                end
            end
            tick;
            cyc++;
        end
        bus.sv_ready = 1'b0;
        cpu_store = 1'b0;
        total++;
        if (got != 256) begin
            bad++; $display("FAIL sv_beats got=%0d exp=256", got);
        end
        total++;
        if (err != 0) begin
            bad++; $display("FAIL sv_data got=%0d exp=0 errors", err);
        end
        total++;
        if (busy !== 1'b0 || bus.sv_valid !== 1'b0) begin
            bad++;
            $display("FAIL sv_end got=%0b%0b exp=00", busy, bus.sv_valid);
        end
        tick;
    endtask

    task automatic test_timeout;
        int sent, cyc, idle, merr;
        logic acc;
        logic [DW-1:0] v;
        bus.ld_req = 1'b1;
        tick;
        bus.ld_req = 1'b0;
        sent = 0; cyc = 0;
        bus.ld_valid = 1'b1;
        while (sent < 10 && cyc < 100) begin
            v = sent[3:0];
            bus.ld_data = ~v;
            acc = bus.ld_ready;
            tick;
            if (acc) sent++;
            cyc++;
        end
        bus.ld_valid = 1'b0;
        idle = 0;
        while (busy && idle < TO + 50) begin
            tick;
            idle++;
        end
        total++;
        if (idle < TO || idle > TO + 3) begin
            bad++;
            $display("FAIL to_latency got=%0d exp=%0d..%0d", idle, TO, TO + 3);
        end
        total++;
        if (busy !== 1'b0 || ld_err !== 1'b1) begin
            bad++; $display("FAIL to_flags got=%0b%0b exp=01", busy, ld_err);
        end
        merr = 0;
        for (int k = 0; k < 256; k++) begin
            v = k[3:0];
            if (k < 10) v = ~v;
            if (mem[k] !== v) merr++;
        end
        total++;
        if (merr != 0) begin
            bad++; $display("FAIL to_array got=%0d exp=0 bad cells", merr);
        end
    endtask

    task automatic test_wr_drop;
        int drops, cyc;
        cpu_store = 1'b1;
        tick; tick;
        cpu_a = 8'h10; cpu_i = 4'h5;
        cpu_ce_n = 1'b0; cpu_rw_n = 1'b0;
        drops = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (cpu_wr_drop === 1'b1) drops++;
        end
        total++;
        if (cpu_o !== 4'hF || busy !== 1'b1) begin
            bad++;
            $display("FAIL wd_cpu_o got=%0h %0b exp=f 1", cpu_o, busy);
        end
        cpu_ce_n = 1'b1; cpu_rw_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            if (cpu_wr_drop === 1'b1) drops++;
        end
        total++;
        if (drops != 1) begin
            bad++; $display("FAIL wd_pulse got=%0d exp=1", drops);
        end
        bus.sv_ready = 1'b1;
        cyc = 0;
        while (busy && cyc < 2000) begin
            tick;
            cyc++;
        end
        bus.sv_ready = 1'b0;
        cpu_store = 1'b0;
        total++;
        if (busy !== 1'b0 || mem[16] !== 4'h0) begin
            bad++;
            $display("FAIL wd_array got=%0b %0h exp=0 0", busy, mem[16]);
        end
        tick;
    endtask

    task automatic test_reset_abort;
        int sent, cyc;
        logic acc, seen;
        logic [AW-1:0] wa;
        logic [DW-1:0] v, wd;
        bus.ld_req = 1'b1;
        tick;
        bus.ld_req = 1'b0;
        total++;
        if (ld_err !== 1'b0) begin
            bad++; $display("FAIL ra_err_clr got=%0b exp=0", ld_err);
        end
        sent = 0; cyc = 0;
        bus.ld_valid = 1'b1;
        while (sent < 100 && cyc < 1000) begin
            v = sent[3:0] + 4'h3;
            bus.ld_data = v;
            acc = bus.ld_ready;
            tick;
            if (acc) sent++;
            cyc++;
        end
        bus.ld_valid = 1'b0;
        cpu_a = 8'h55; cpu_ce_n = 1'b0; cpu_rw_n = 1'b1;
        reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || bus.ld_ready !== 1'b0 ||
            bus.sv_valid !== 1'b0 || ld_err !== 1'b0) begin
            bad++;
            $display("FAIL ra_flags got=%0b%0b%0b%0b exp=0000",
                     busy, bus.ld_ready, bus.sv_valid, ld_err);
        end
        total++;
        if (bus.nv_ce_n !== 1'b1 || bus.nv_rw_n !== 1'b1 ||
            bus.nv_a !== 8'h00 || bus.nv_i !== 4'h0) begin
            bad++;
            $display("FAIL ra_nv got=%0b%0b %0h %0h exp=11 0 0",
                     bus.nv_ce_n, bus.nv_rw_n, bus.nv_a, bus.nv_i);
        end
        total++;
        if (mem[98] !== 4'h5 || mem[0] !== 4'h3) begin
            bad++;
            $display("FAIL ra_kept got=%0h %0h exp=5 3", mem[98], mem[0]);
        end
        cpu_ce_n = 1'b1; cpu_a = '0;
        tick;
        reset_n = 1'b1;
        tick;
        bus.ld_req = 1'b1;
        tick;
        bus.ld_req = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data = 4'hC;
        seen = 1'b0; wa = '1; wd = '0; cyc = 0;
        while (!seen && cyc < 20) begin
            if (bus.nv_rw_n == 1'b0) begin
                seen = 1'b1;
                wa = bus.nv_a;
                wd = bus.nv_i;
            end
            tick;
            cyc++;
        end
        bus.ld_valid = 1'b0;
        total++;
        if (!seen || wa !== 8'h00 || wd !== 4'hC) begin
            bad++;
            $display("FAIL ra_restart got=%0b %0h %0h exp=1 0 c", seen, wa, wd);
        end
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_cpu_access;
        test_load;
        test_save;
        test_timeout;
        test_wr_drop;
        test_reset_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
